// File: rtl/smi_frame_types.sv
// Shared SMI frame type identifiers and flit field widths.
// Also holds the routing state encoding used by the request router.
package smi_frame_types;

  localparam logic [7:0] READ_REQ_ID_BYTE   = 8'h01;
  localparam logic [7:0] WRITE_REQ_ID_BYTE  = 8'h02;
  localparam logic [7:0] READ_RESP_ID_BYTE  = 8'hFD;
  localparam logic [7:0] WRITE_RESP_ID_BYTE = 8'hFE;

  localparam int EOFC_WIDTH = 8;

  typedef enum logic [1:0] {
    RouteIdle,
    RouteRead,
    RouteWrite,
    RouteDiscard
  } route_state_t;

endpackage

// File: rtl/smi_request_type_router_flit_reg.sv
// One-entry SMI flit register; holds its contents while downstream stops.
// Stop toward the source is only raised when a held flit is blocked.
module smi_flit_register
  import smi_frame_types::*;
#(
  parameter int DataWidth = 128
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  srcReady,
  input  logic [EOFC_WIDTH-1:0] srcEofc,
  input  logic [DataWidth-1:0]  srcData,
  output logic                  srcStop,
  output logic                  dstReady,
  output logic [EOFC_WIDTH-1:0] dstEofc,
  output logic [DataWidth-1:0]  dstData,
  input  logic                  dstStop
);

  logic hold;

  assign hold    = dstReady & dstStop;
  assign srcStop = hold;

  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      dstReady <= 1'b0;
    end else if (!hold) begin
      dstReady <= srcReady;
    end
  end

  always_ff @(posedge clk) begin
    if (!hold) begin
      dstEofc <= srcEofc;
      dstData <= srcData;
    end
  end

endmodule

// File: rtl/smi_request_type_router.sv
// Steers SMI request frames to the read or write adaptor by header type.
// Unknown frame types are swallowed and tallied in a saturating counter.
module smi_request_type_router
  import smi_frame_types::*;
#(
  parameter int         DataIndexSize = 4,
  parameter int         DataWidth     = (1 << DataIndexSize) * 8,
  parameter logic [7:0] ReadTypeId    = READ_REQ_ID_BYTE,
  parameter logic [7:0] WriteTypeId   = WRITE_REQ_ID_BYTE
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  smiReqReady,
  input  logic [EOFC_WIDTH-1:0] smiReqEofc,
  input  logic [DataWidth-1:0]  smiReqData,
  output logic                  smiReqStop,
  output logic                  smiReadReqReady,
  output logic [EOFC_WIDTH-1:0] smiReadReqEofc,
  output logic [DataWidth-1:0]  smiReadReqData,
  input  logic                  smiReadReqStop,
  output logic                  smiWriteReqReady,
  output logic [EOFC_WIDTH-1:0] smiWriteReqEofc,
  output logic [DataWidth-1:0]  smiWriteReqData,
  input  logic                  smiWriteReqStop,
  output logic [15:0]           dropCount
);

  logic                  readyQ;
  logic [EOFC_WIDTH-1:0] eofcQ;
  logic [DataWidth-1:0]  dataQ;
  route_state_t          state;

  logic isRead;
  logic isWrite;
  logic lastFlit;
  logic readSel;
  logic writeSel;
  logic readStop;
  logic writeStop;
  logic halt;
  logic advance;

  assign isRead   = dataQ[7:0] == ReadTypeId;
  assign isWrite  = dataQ[7:0] == WriteTypeId;
  assign lastFlit = eofcQ != '0;

  // In Idle the held flit is a header and is steered by its own type byte.
  always_comb begin
    readSel  = 1'b0;
    writeSel = 1'b0;
    unique case (state)
      RouteIdle: begin
        readSel  = isRead;
        writeSel = isWrite;
      end
      RouteRead:  readSel  = 1'b1;
      RouteWrite: writeSel = 1'b1;
      default: ;
    endcase
  end

  assign halt       = (readSel & readStop) | (writeSel & writeStop);
  assign advance    = readyQ & ~halt;
  assign smiReqStop = readyQ & halt;

  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      readyQ <= 1'b0;
    end else if (!smiReqStop) begin
      readyQ <= smiReqReady;
    end
  end

  always_ff @(posedge clk) begin
    if (!smiReqStop) begin
      eofcQ <= smiReqEofc;
      dataQ <= smiReqData;
    end
  end

  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      state     <= RouteIdle;
      dropCount <= 16'h0000;
    end else begin
      unique case (state)
        RouteIdle: begin
          if (advance) begin
            if (!isRead && !isWrite && dropCount != 16'hFFFF) begin
              dropCount <= dropCount + 16'h0001;
            end
            if (!lastFlit) begin
              state <= isRead  ? RouteRead  :
                       isWrite ? RouteWrite : RouteDiscard;
            end
          end
        end
        RouteRead, RouteWrite, RouteDiscard: begin
          if (advance && lastFlit) begin
            state <= RouteIdle;
          end
        end
        default: state <= RouteIdle;
      endcase
    end
  end

  smi_flit_register #(
    .DataWidth(DataWidth)
  ) readReg (
    .clk     (clk),
    .srst    (srst),
    .srcReady(readyQ & readSel),
    .srcEofc (eofcQ),
    .srcData (dataQ),
    .srcStop (readStop),
    .dstReady(smiReadReqReady),
    .dstEofc (smiReadReqEofc),
    .dstData (smiReadReqData),
    .dstStop (smiReadReqStop)
  );

  smi_flit_register #(
    .DataWidth(DataWidth)
  ) writeReg (
    .clk     (clk),
    .srst    (srst),
    .srcReady(readyQ & writeSel),
    .srcEofc (eofcQ),
    .srcData (dataQ),
    .srcStop (writeStop),
    .dstReady(smiWriteReqReady),
    .dstEofc (smiWriteReqEofc),
    .dstData (smiWriteReqData),
    .dstStop (smiWriteReqStop)
  );

endmodule

// File: tb/tb_smi_request_type_router.sv
// Bench for smi_request_type_router: queue model of per-path frame streams.
// Directed scenarios plus randomized frames, gaps and downstream stops.
module tb_smi_request_type_router;

  localparam int DW = 128;

  typedef struct {
    logic [DW-1:0] data;
    logic [7:0]    eofc;
    bit            dropHdr;
  } flit_t;

  logic          clk = 1'b0;
  logic          srst = 1'b0;
  logic          smiReqReady = 1'b0;
  logic [7:0]    smiReqEofc = '0;
  logic [DW-1:0] smiReqData = '0;
  logic          smiReqStop;
  logic          smiReadReqReady;
  logic [7:0]    smiReadReqEofc;
  logic [DW-1:0] smiReadReqData;
  logic          smiReadReqStop = 1'b0;
  logic          smiWriteReqReady;
  logic [7:0]    smiWriteReqEofc;
  logic [DW-1:0] smiWriteReqData;
  logic          smiWriteReqStop = 1'b0;
  logic [15:0]   dropCount;

  always #5 clk = ~clk;

  smi_request_type_router dut (
    .clk             (clk),
    .srst            (srst),
    .smiReqReady     (smiReqReady),
    .smiReqEofc      (smiReqEofc),
    .smiReqData      (smiReqData),
    .smiReqStop      (smiReqStop),
    .smiReadReqReady (smiReadReqReady),
    .smiReadReqEofc  (smiReadReqEofc),
    .smiReadReqData  (smiReadReqData),
    .smiReadReqStop  (smiReadReqStop),
    .smiWriteReqReady(smiWriteReqReady),
    .smiWriteReqEofc (smiWriteReqEofc),
    .smiWriteReqData (smiWriteReqData),
    .smiWriteReqStop (smiWriteReqStop),
    .dropCount       (dropCount)
  );

  flit_t srcQ[$];
  flit_t expRd[$];
  flit_t expWr[$];
  int    inAccCyc[$];
  int    rdOutCyc[$];
  int    wrOutCyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int inAccCount = 0;
  int acceptedDrops = 0;
  int lagDrops = 0;
  bit gapMode = 0;
  bit randStop = 0;
  int rdHold = 0;
  int wrHold = 0;
  bit wrSeen = 0;
  bit anyOutSeen = 0;
  bit reqStopSeen = 0;

  task automatic check(string name, logic [DW+7:0] act, logic [DW+7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rndData();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // lastEofc == 0 picks a random non-zero end marker
  task automatic addFrame(logic [7:0] typ, int len, logic [7:0] lastEofc);
    flit_t f;
    for (int i = 0; i < len; i++) begin
      f.data = rndData();
      if (i == 0) f.data[7:0] = typ;
      if (i == len - 1)
        f.eofc = (lastEofc != 0) ? lastEofc : 8'($urandom_range(1, 255));
      else
        f.eofc = 8'h00;
      f.dropHdr = (i == 0) && (typ != 8'h01) && (typ != 8'h02);
      srcQ.push_back(f);
      if (typ == 8'h01) expRd.push_back(f);
      else if (typ == 8'h02) expWr.push_back(f);
    end
  endtask

  task automatic clearLogs();
    inAccCyc.delete();
    rdOutCyc.delete();
    wrOutCyc.delete();
    wrSeen = 0;
    anyOutSeen = 0;
    reqStopSeen = 0;
  endtask

  task automatic waitDrain(int budget);
    int n = 0;
    while ((srcQ.size() + expRd.size() + expWr.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((srcQ.size() + expRd.size() + expWr.size()) != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d/%0d flits left, required 0",
               srcQ.size(), expRd.size(), expWr.size());
      srcQ.delete();
      expRd.delete();
      expWr.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Driver and compare process: drive at negedge, sample 1 before posedge.
  initial begin
    flit_t f;
    forever begin
      @(negedge clk);
      if (srcQ.size() > 0 && (!gapMode || $urandom_range(3) != 0)) begin
        smiReqReady = 1'b1;
        smiReqData  = srcQ[0].data;
        smiReqEofc  = srcQ[0].eofc;
      end else begin
        smiReqReady = 1'b0;
        smiReqData  = rndData();
        smiReqEofc  = 8'($urandom);
      end
      smiReadReqStop  = (rdHold > 0) || (randStop && $urandom_range(2) == 0);
      smiWriteReqStop = (wrHold > 0) || (randStop && $urandom_range(2) == 0);
      if (rdHold > 0) rdHold--;
      if (wrHold > 0) wrHold--;
      #4;
      cyc++;
      if (!srst) begin
        srcQ.delete();
        expRd.delete();
        expWr.delete();
        acceptedDrops = 0;
        lagDrops = 0;
      end else begin
        if (smiReadReqReady) anyOutSeen = 1;
        if (smiWriteReqReady) begin
          anyOutSeen = 1;
          wrSeen = 1;
        end
        if (smiReqStop) reqStopSeen = 1;
        if (smiReadReqReady && !smiReadReqStop) begin
          if (expRd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_extra: actual flit %0h, required none", smiReadReqData);
          end else begin
            f = expRd.pop_front();
            check("read_flit", {smiReadReqEofc, smiReadReqData}, {f.eofc, f.data});
          end
          rdOutCyc.push_back(cyc);
        end
        if (smiWriteReqReady && !smiWriteReqStop) begin
          if (expWr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write_extra: actual flit %0h, required none", smiWriteReqData);
          end else begin
            f = expWr.pop_front();
            check("write_flit", {smiWriteReqEofc, smiWriteReqData}, {f.eofc, f.data});
          end
          wrOutCyc.push_back(cyc);
        end
        check("drop_count", dropCount, (lagDrops > 65535) ? 65535 : lagDrops);
        lagDrops = acceptedDrops;
        if (smiReqReady && !smiReqStop && srcQ.size() > 0) begin
          f = srcQ.pop_front();
          if (f.dropHdr) acceptedDrops++;
          inAccCyc.push_back(cyc);
          inAccCount++;
        end
      end
    end
  end

  initial begin
    int n;
    int base;
    logic [7:0] typ;
    srst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_reqstop", smiReqStop, 0);
    check("reset_rdready", smiReadReqReady, 0);
    check("reset_wrready", smiWriteReqReady, 0);
    check("reset_drops", dropCount, 0);
    srst = 1'b1;
    repeat (2) @(negedge clk);

    // 3-flit read frame, no stops
    clearLogs();
    addFrame(8'h01, 3, 8'd16);
    waitDrain(50);
    check("t1_rd_count", rdOutCyc.size(), 3);
    check("t1_wr_idle", wrSeen, 0);
    if (rdOutCyc.size() == 3 && inAccCyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("t1_latency", rdOutCyc[i] - inAccCyc[i], 2);
        check("t1_consecutive", rdOutCyc[i] - rdOutCyc[0], i);
      end
    end

    // single-flit write then 2-flit read, back to back
    clearLogs();
    addFrame(8'h02, 1, 8'd16);
    addFrame(8'h01, 2, 8'd16);
    waitDrain(50);
    check("t2_wr_count", wrOutCyc.size(), 1);
    check("t2_rd_count", rdOutCyc.size(), 2);
    check("t2_no_stop", reqStopSeen, 0);
    if (wrOutCyc.size() == 1 && rdOutCyc.size() == 2) begin
      check("t2_rd_after_wr", rdOutCyc[0] - wrOutCyc[0], 1);
      check("t2_rd_no_bubble", rdOutCyc[1] - rdOutCyc[0], 1);
    end

    // 4-flit discarded frame
    clearLogs();
    check("t3_drops_before", dropCount, 0);
    addFrame(8'h7F, 4, 8'd16);
    waitDrain(50);
    check("t3_drops_after", dropCount, 1);
    check("t3_no_output", anyOutSeen, 0);
    check("t3_no_stop", reqStopSeen, 0);

    // read stop held 5 cycles, write stop held too
    clearLogs();
    rdHold = 5;
    wrHold = 5;
    addFrame(8'h01, 4, 8'd16);
    waitDrain(100);
    check("t4_stop_seen", reqStopSeen, 1);
    check("t4_rd_count", rdOutCyc.size(), 4);
    check("t4_wr_idle", wrSeen, 0);

    // randomized frames, gaps and stops
    gapMode = 1;
    randStop = 1;
    for (int b = 0; b < 15; b++) begin
      for (int k = 0; k < 20; k++) begin
        n = $urandom_range(0, 3);
        typ = (n == 1) ? 8'h02 : (n == 2) ? 8'($urandom) : 8'h01;
        addFrame(typ, $urandom_range(1, 6), 8'h00);
      end
      waitDrain(3000);
    end
    gapMode = 0;
    randStop = 0;
    repeat (3) @(negedge clk);

    // reset during the 2nd flit of a 3-flit read frame
    clearLogs();
    base = inAccCount;
    addFrame(8'h01, 3, 8'd16);
    n = 0;
    while (inAccCount < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_2nd", inAccCount >= base + 2, 1);
    @(posedge clk);
    #1;
    check("t5_rd_before", smiReadReqReady, 1);
    #1;
    srst = 1'b0;
    #1;
    check("t5_rd_dropped", smiReadReqReady, 0);
    check("t5_reqstop", smiReqStop, 0);
    check("t5_drops_reset", dropCount, 0);
    repeat (2) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    clearLogs();
    addFrame(8'h02, 2, 8'd16);
    waitDrain(50);
    check("t5_wr_count", wrOutCyc.size(), 2);
    check("t5_rd_idle", rdOutCyc.size(), 0);

    // saturate drop counter
    for (int i = 0; i < 65534; i++) addFrame(8'hA5, 1, 8'd16);
    waitDrain(70000);
    check("t6_drops_fffe", dropCount, 16'hFFFE);
    addFrame(8'h7F, 1, 8'd16);
    addFrame(8'h00, 1, 8'd16);
    waitDrain(50);
    check("t6_drops_sat", dropCount, 16'hFFFF);
    repeat (5) @(negedge clk);
    check("t6_drops_hold", dropCount, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
